// File: rtl/uart_pkg.sv
// Shared types and sizing constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned BAUD_DIV_W      = 16;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// TX holding buffer: circular storage with show-ahead head byte and a selectable
// capacity of DEPTH entries (FIFO mode) or one entry (THR mode).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             single,
  input  logic             push,
  input  logic             pop,
  input  uart_byte_t       wr_data,
  output uart_byte_t       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             lost
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  uart_byte_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop, do_push, do_ovwr, blocked;

  assign empty = (count_q == '0);
  assign full  = single ? !empty : (count_q == CNT_W'(DEPTH));

  // A pop on an empty buffer is ignored, so it never frees a slot for a write.
  assign do_pop  = pop & !empty & !flush;
  assign blocked = push & !flush & full & !do_pop;
  assign do_push = push & !flush & !blocked;
  assign do_ovwr = blocked & single;
  assign lost    = blocked;

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end else if (do_ovwr) begin
        // THR mode keeps its single byte at the read pointer; replace it in place.
        mem_q[rd_ptr_q] <= wr_data;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// TX sequencing front end: divisor-latch baud tick generator, holding buffer mode control,
// THRE/TEMT status, THRE interrupt pulse and sticky overflow flag.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BAUD_DIV_W-1:0] divisor,
  input  logic                  divisor_wr,
  input  logic                  fifo_enable,
  input  logic                  fifo_reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  overflow_clr,
  input  logic                  pop,
  input  logic                  sreg_empty,
  output logic                  baud_pulse,
  output logic                  tx_hold_reg_empty,
  output logic [7:0]            din,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  thre,
  output logic                  temt,
  output logic                  thre_irq,
  output logic                  overflow
);

  logic [BAUD_DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic                  baud_pulse_q, baud_pulse_d;
  logic                  fifo_enable_q;
  logic                  flush, empty, full, lost;
  logic                  overflow_q, thre_prev_q, thre_irq_q;
  uart_byte_t            head;

  // Divisor of zero freezes the counter; a divisor write restarts it without a tick.
  always_comb begin
    baud_cnt_d   = baud_cnt_q;
    baud_pulse_d = 1'b0;
    if (divisor_wr) begin
      baud_cnt_d = divisor - BAUD_DIV_W'(1);
    end else if (divisor != '0) begin
      if (baud_cnt_q == '0) begin
        baud_pulse_d = 1'b1;
        baud_cnt_d   = divisor - BAUD_DIV_W'(1);
      end else begin
        baud_cnt_d = baud_cnt_q - BAUD_DIV_W'(1);
      end
    end
  end

  // Switching between FIFO and THR mode discards the buffer like an explicit flush.
  assign flush = fifo_reset | (fifo_enable != fifo_enable_q);

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .single  (!fifo_enable),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty),
    .lost    (lost)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q    <= divisor - BAUD_DIV_W'(1);
      baud_pulse_q  <= 1'b0;
      fifo_enable_q <= fifo_enable;
      overflow_q    <= 1'b0;
      thre_prev_q   <= 1'b1;
      thre_irq_q    <= 1'b0;
    end else begin
      baud_cnt_q    <= baud_cnt_d;
      baud_pulse_q  <= baud_pulse_d;
      fifo_enable_q <= fifo_enable;
      thre_prev_q   <= empty;
      thre_irq_q    <= empty & !thre_prev_q;
      if (flush) begin
        overflow_q <= 1'b0;
      end else if (lost) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign baud_pulse        = baud_pulse_q;
  assign tx_hold_reg_empty = empty;
  assign thre              = empty;
  assign temt              = empty & sreg_empty;
  assign thre_irq          = thre_irq_q;
  assign overflow          = overflow_q;
  assign din               = head;

  // full is only needed inside the buffer; keep it observable for debug probes.
  logic unused_full;
  assign unused_full = full;

endmodule
